// File: rtl/bf_pkg.sv
// Shared sizing constants and controller state encoding for the Blowfish key schedule.
package bf_pkg;
    localparam int P_WORDS = 18;
    localparam int S_WORDS = 1024;
    localparam int KEY_MAX = 18;
    localparam int N_CALLS = (P_WORDS + S_WORDS) / 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_XOR_RD,
        ST_XOR_WR,
        ST_ENC_START,
        ST_ENC_WAIT,
        ST_WR_L,
        ST_WR_R,
        ST_DONE
    } bf_kx_state_t;
endpackage

// File: rtl/bf_key_expand.sv
// Blowfish/bcrypt key-schedule controller: folds the key into P, then chains
// encipher calls whose output pairs overwrite P followed by the S-boxes.
module bf_key_expand
    import bf_pkg::*;
(
    input  logic         clk,
    input  logic         reset_l,
    input  logic         start,
    input  logic         use_salt,
    input  logic [127:0] salt,
    input  logic [4:0]   key_words,
    output logic [4:0]   key_addr,
    input  logic [31:0]  key_data,
    output logic         p_own,
    output logic [4:0]   P_addr,
    input  logic [31:0]  P_rd_data,
    output logic         P_wr_en,
    output logic [31:0]  P_wr_data,
    output logic         S_wr_en,
    output logic [9:0]   S_wr_addr,
    output logic [31:0]  S_wr_data,
    output logic         enc_start,
    output logic [31:0]  enc_xl,
    output logic [31:0]  enc_xr,
    input  logic         enc_done,
    input  logic [31:0]  enc_xl_out,
    input  logic [31:0]  enc_xr_out,
    output logic         busy,
    output logic         done
);

    bf_kx_state_t state_q, state_d;
    logic [4:0]   i_q, i_d, k_q, k_d, kw_q, kw_d;
    logic [9:0]   j_q, j_d;
    logic [31:0]  l_q, l_d, r_q, r_d;
    logic         use_salt_q, use_salt_d;
    logic [127:0] salt_q, salt_d;

    logic [4:0]   kw_clamp;
    logic [31:0]  salt_l, salt_r, xl_in, xr_in, wr_word;
    logic [10:0]  wr_idx;

    assign kw_clamp = (key_words == 5'd0 || key_words > 5'(KEY_MAX)) ? 5'(KEY_MAX) : key_words;

    // Call j uses salt words 2j mod 4 and 2j+1 mod 4, i.e. pair {0,1} or {2,3}.
    assign salt_l = j_q[0] ? salt_q[63:32] : salt_q[127:96];
    assign salt_r = j_q[0] ? salt_q[31:0]  : salt_q[95:64];
    assign xl_in  = l_q ^ (use_salt_q ? salt_l : 32'h0);
    assign xr_in  = r_q ^ (use_salt_q ? salt_r : 32'h0);

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            state_q    <= ST_IDLE;
            i_q        <= '0;
            k_q        <= '0;
            kw_q       <= '0;
            j_q        <= '0;
            l_q        <= '0;
            r_q        <= '0;
            use_salt_q <= 1'b0;
            salt_q     <= '0;
        end else begin
            state_q    <= state_d;
            i_q        <= i_d;
            k_q        <= k_d;
            kw_q       <= kw_d;
            j_q        <= j_d;
            l_q        <= l_d;
            r_q        <= r_d;
            use_salt_q <= use_salt_d;
            salt_q     <= salt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        i_d        = i_q;
        k_d        = k_q;
        kw_d       = kw_q;
        j_d        = j_q;
        l_d        = l_q;
        r_d        = r_q;
        use_salt_d = use_salt_q;
        salt_d     = salt_q;
        key_addr   = '0;
        p_own      = 1'b0;
        P_addr     = '0;
        P_wr_en    = 1'b0;
        P_wr_data  = '0;
        S_wr_en    = 1'b0;
        S_wr_addr  = '0;
        S_wr_data  = '0;
        enc_start  = 1'b0;
        enc_xl     = '0;
        enc_xr     = '0;
        busy       = 1'b1;
        done       = 1'b0;
        wr_idx     = {j_q, 1'b0};
        wr_word    = l_q;

        case (state_q)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    i_d        = '0;
                    k_d        = '0;
                    j_d        = '0;
                    l_d        = '0;
                    r_d        = '0;
                    kw_d       = kw_clamp;
                    use_salt_d = use_salt;
                    salt_d     = salt;
                    state_d    = ST_XOR_RD;
                end
            end
            ST_XOR_RD: begin
                p_own    = 1'b1;
                P_addr   = i_q;
                key_addr = k_q;
                state_d  = ST_XOR_WR;
            end
            ST_XOR_WR: begin
                p_own     = 1'b1;
                P_addr    = i_q;
                key_addr  = k_q;
                P_wr_en   = 1'b1;
                P_wr_data = P_rd_data ^ key_data;
                k_d       = (k_q == kw_q - 5'd1) ? '0 : k_q + 5'd1;
                if (i_q == 5'(P_WORDS - 1)) begin
                    state_d = ST_ENC_START;
                end else begin
                    i_d     = i_q + 5'd1;
                    state_d = ST_XOR_RD;
                end
            end
            ST_ENC_START: begin
                enc_start = 1'b1;
                enc_xl    = xl_in;
                enc_xr    = xr_in;
                state_d   = ST_ENC_WAIT;
            end
            ST_ENC_WAIT: begin
                // Inputs held so encipher may sample them any time before done.
                enc_xl = xl_in;
                enc_xr = xr_in;
                if (enc_done) begin
                    l_d     = enc_xl_out;
                    r_d     = enc_xr_out;
                    state_d = ST_WR_L;
                end
            end
            ST_WR_L, ST_WR_R: begin
                if (state_q == ST_WR_R) begin
                    wr_idx  = {j_q, 1'b1};
                    wr_word = r_q;
                end
                if (wr_idx < 11'(P_WORDS)) begin
                    p_own     = 1'b1;
                    P_addr    = wr_idx[4:0];
                    P_wr_en   = 1'b1;
                    P_wr_data = wr_word;
                end else begin
                    S_wr_en   = 1'b1;
                    S_wr_addr = 10'(wr_idx - 11'(P_WORDS));
                    S_wr_data = wr_word;
                end
                if (state_q == ST_WR_L) begin
                    state_d = ST_WR_R;
                end else if (j_q == 10'(N_CALLS - 1)) begin
                    state_d = ST_DONE;
                end else begin
                    j_d     = j_q + 10'd1;
                    state_d = ST_ENC_START;
                end
            end
            ST_DONE: begin
                busy    = 1'b0;
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_bf_key_expand.sv
// Self-checking bench for bf_key_expand: P/S/key RAM models, a stub encipher
// (xl+1, xr+2), and a reference model of the whole key schedule.
module tb_bf_key_expand;
    localparam int PW = 18;
    localparam int SW = 1024;
    localparam int NC = (PW + SW) / 2;

    logic         clk = 1'b0;
    logic         reset_l = 1'b1;
    logic         start = 1'b0;
    logic         use_salt = 1'b0;
    logic [127:0] salt = '0;
    logic [4:0]   key_words = '0;
    logic [4:0]   key_addr;
    logic [31:0]  key_data = '0;
    logic         p_own;
    logic [4:0]   P_addr;
    logic [31:0]  P_rd_data = '0;
    logic         P_wr_en;
    logic [31:0]  P_wr_data;
    logic         S_wr_en;
    logic [9:0]   S_wr_addr;
    logic [31:0]  S_wr_data;
    logic         enc_start;
    logic [31:0]  enc_xl, enc_xr;
    logic         enc_done;
    logic [31:0]  enc_xl_out = '0, enc_xr_out = '0;
    logic         busy, done;

    bf_key_expand dut (
        .clk(clk), .reset_l(reset_l), .start(start), .use_salt(use_salt), .salt(salt),
        .key_words(key_words), .key_addr(key_addr), .key_data(key_data), .p_own(p_own),
        .P_addr(P_addr), .P_rd_data(P_rd_data), .P_wr_en(P_wr_en), .P_wr_data(P_wr_data),
        .S_wr_en(S_wr_en), .S_wr_addr(S_wr_addr), .S_wr_data(S_wr_data),
        .enc_start(enc_start), .enc_xl(enc_xl), .enc_xr(enc_xr), .enc_done(enc_done),
        .enc_xl_out(enc_xl_out), .enc_xr_out(enc_xr_out), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    logic [153:0] outs;
    assign outs = {key_addr, p_own, P_addr, P_wr_en, P_wr_data, S_wr_en, S_wr_addr, S_wr_data,
                   enc_start, enc_xl, enc_xr, busy, done};

    // ---------------- memories ----------------
    logic [31:0] key_mem [32];
    logic [31:0] p_init  [PW];
    logic [31:0] p_mem   [32];
    logic [31:0] s_mem   [SW];
    logic        load_req = 1'b0;

    always @(posedge clk) begin
        if (load_req) begin
            for (int n = 0; n < 32; n++) p_mem[n] <= (n < PW) ? p_init[n] : 32'h0;
            for (int n = 0; n < SW; n++) s_mem[n] <= 32'h0;
        end else begin
            if (p_own && P_wr_en) p_mem[P_addr] <= P_wr_data;
            if (S_wr_en) s_mem[S_wr_addr] <= S_wr_data;
        end
        P_rd_data <= p_mem[P_addr];
        key_data  <= key_mem[key_addr];
    end

    // ---------------- stub encipher ----------------
    int          stub_lat = 3;
    int          stub_cnt = 0;
    logic        stub_pend = 1'b0, stub_done = 1'b0, inj_done = 1'b0;
    logic [31:0] stub_xl = '0, stub_xr = '0;
    assign enc_done = stub_done | inj_done;

    always @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            stub_pend <= 1'b0; stub_done <= 1'b0; stub_cnt <= 0;
            enc_xl_out <= '0; enc_xr_out <= '0;
        end else begin
            stub_done <= 1'b0;
            if (enc_start) begin
                stub_pend <= 1'b1; stub_cnt <= stub_lat; stub_xl <= enc_xl; stub_xr <= enc_xr;
            end else if (stub_pend) begin
                if (stub_cnt <= 1) begin
                    stub_pend <= 1'b0; stub_done <= 1'b1;
                    enc_xl_out <= stub_xl + 32'd1; enc_xr_out <= stub_xr + 32'd2;
                end else stub_cnt <= stub_cnt - 1;
            end
        end
    end

    // ---------------- monitor ----------------
    int n_pw = 0, n_sw = 0, n_enc = 0, n_done = 0, n_multi = 0, n_own_bad = 0, last_s = -1;
    logic [31:0] pw_addr_q[$], pw_data_q[$], ka_q[$], xl_q[$], xr_q[$];

    always @(negedge clk) begin
        if (P_wr_en) begin pw_addr_q.push_back(32'(P_addr)); pw_data_q.push_back(P_wr_data); n_pw++; end
        if (S_wr_en) begin n_sw++; last_s = int'(S_wr_addr); end
        if (P_wr_en && S_wr_en) n_multi++;
        if (p_own && !P_wr_en) ka_q.push_back(32'(key_addr));
        if (enc_start) begin
            n_enc++; xl_q.push_back(enc_xl); xr_q.push_back(enc_xr);
            if (p_own) n_own_bad++;
        end
        if (done) n_done++;
    end

    // ---------------- reference model ----------------
    logic [31:0] exp_ps [PW+SW];
    logic [31:0] exp_p1 [PW];
    logic [31:0] exp_xl [NC];
    logic [31:0] exp_xr [NC];
    int          exp_eff;

    task automatic model(input logic [4:0] kw, input bit us, input logic [127:0] sl);
        logic [31:0] L, R, xl, xr;
        logic [31:0] sw [4];
        exp_eff = (kw == 5'd0 || kw > 5'd18) ? 18 : int'(kw);
        for (int n = 0; n < PW; n++) begin
            exp_p1[n] = p_init[n] ^ key_mem[n % exp_eff];
            exp_ps[n] = exp_p1[n];
        end
        for (int n = 0; n < 4; n++) sw[n] = sl[127 - 32*n -: 32];
        L = 0; R = 0;
        // P and S form one flat destination array; call c writes entries 2c and 2c+1.
        for (int c = 0; c < NC; c++) begin
            xl = L ^ (us ? sw[(2*c) % 4] : 32'h0);
            xr = R ^ (us ? sw[(2*c+1) % 4] : 32'h0);
            exp_xl[c] = xl; exp_xr[c] = xr;
            L = xl + 32'd1; R = xr + 32'd2;
            exp_ps[2*c] = L; exp_ps[2*c+1] = R;
        end
    endtask

    int b_pw = 0, b_sw = 0, b_enc = 0, b_done = 0, b_multi = 0, b_own = 0, b_ka = 0;
    int n_checks = 0, n_pass = 0;

    function automatic int mem_mm();
        int m = 0;
        for (int n = 0; n < PW; n++) if (p_mem[n] !== exp_ps[n]) m++;
        for (int n = 0; n < SW; n++) if (s_mem[n] !== exp_ps[PW+n]) m++;
        return m;
    endfunction

    function automatic int p1_mm();
        int m = 0;
        if (pw_addr_q.size() < b_pw + PW) return 99;
        for (int n = 0; n < PW; n++)
            if (pw_addr_q[b_pw+n] !== 32'(n) || pw_data_q[b_pw+n] !== exp_p1[n]) m++;
        return m;
    endfunction

    function automatic int ka_mm();
        int m = 0;
        if (ka_q.size() < b_ka + PW) return 99;
        for (int n = 0; n < PW; n++) if (ka_q[b_ka+n] !== 32'(n % exp_eff)) m++;
        return m;
    endfunction

    function automatic int enc_mm();
        int m = 0;
        if (xl_q.size() < b_enc + NC) return 9999;
        for (int c = 0; c < NC; c++)
            if (xl_q[b_enc+c] !== exp_xl[c] || xr_q[b_enc+c] !== exp_xr[c]) m++;
        return m;
    endfunction

    task automatic rand_mem();
        for (int n = 0; n < 32; n++) key_mem[n] = $urandom;
        for (int n = 0; n < PW; n++) p_init[n] = $urandom;
    endtask

    task automatic load_and_snap();
        @(negedge clk); load_req = 1'b1;
        @(negedge clk); load_req = 1'b0;
        b_pw = n_pw; b_sw = n_sw; b_enc = n_enc; b_done = n_done;
        b_multi = n_multi; b_own = n_own_bad; b_ka = ka_q.size();
    endtask

    // Runs one full schedule; inputs are scrambled after start to prove they are latched.
    task automatic run_seq(input logic [4:0] kw, input bit us, input logic [127:0] sl,
                           input bit inj, output bit timed_out);
        model(kw, us, sl);
        load_and_snap();
        key_words = kw; use_salt = us; salt = sl; start = 1'b1;
        @(negedge clk); start = 1'b0;
        key_words = 5'($urandom); use_salt = 1'($urandom);
        salt = {$urandom, $urandom, $urandom, $urandom};
        timed_out = 1'b1;
        for (int c = 0; c < 20000; c++) begin
            if (n_done > b_done) begin timed_out = 1'b0; break; end
            if (inj) begin
                start    = busy && ($urandom_range(0, 7) == 0);
                inj_done = (c == 10);
            end
            @(negedge clk); #1;
        end
        start = 1'b0; inj_done = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        #1 reset_l = 1'b0;
        #1;
        n_checks++; if (outs !== '0) $display("FAIL reset_outs: got %h want 0", outs); else n_pass++;
        repeat (3) @(negedge clk);
        n_checks++; if (outs !== '0) $display("FAIL reset_hold: got %h want 0", outs); else n_pass++;
        reset_l = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_key_one();
        bit to;
        for (int n = 0; n < 32; n++) key_mem[n] = $urandom;
        key_mem[0] = 32'hFFFF_FFFF;
        for (int n = 0; n < PW; n++) p_init[n] = 32'(n);
        stub_lat = 1;
        run_seq(5'd1, 1'b0, '0, 1'b0, to);
        n_checks++; if (to) $display("FAIL k1_timeout: done not seen"); else n_pass++;
        n_checks++; if (p1_mm() !== 0) $display("FAIL k1_p1_trace: %0d bad writes want 0", p1_mm()); else n_pass++;
        n_checks++; if (pw_data_q[b_pw+17] !== 32'hFFFF_FFEE)
            $display("FAIL k1_p17: got %h want ffffffee", pw_data_q[b_pw+17]); else n_pass++;
        n_checks++; if (ka_mm() !== 0) $display("FAIL k1_key_addr: %0d bad want 0", ka_mm()); else n_pass++;
        n_checks++; if (mem_mm() !== 0) $display("FAIL k1_mem: %0d bad words want 0", mem_mm()); else n_pass++;
    endtask

    task automatic test_key_len();
        bit to;
        int kws [5];
        logic [31:0] tr18 [PW];
        int m;
        kws = '{3, 18, 0, 7, 25};
        kws[3] = $urandom_range(1, 17);
        rand_mem();
        stub_lat = 1;
        for (int t = 0; t < 5; t++) begin
            run_seq(5'(kws[t]), 1'b0, '0, 1'b0, to);
            n_checks++; if (to) $display("FAIL klen_timeout kw=%0d", kws[t]); else n_pass++;
            n_checks++; if (ka_mm() !== 0) $display("FAIL klen_key_addr kw=%0d: %0d bad want 0", kws[t], ka_mm()); else n_pass++;
            n_checks++; if (p1_mm() !== 0) $display("FAIL klen_p1 kw=%0d: %0d bad want 0", kws[t], p1_mm()); else n_pass++;
            n_checks++; if (mem_mm() !== 0) $display("FAIL klen_mem kw=%0d: %0d bad want 0", kws[t], mem_mm()); else n_pass++;
            if (t == 1 && pw_data_q.size() >= b_pw + PW)
                for (int n = 0; n < PW; n++) tr18[n] = pw_data_q[b_pw+n];
            if (t == 2) begin
                m = 0;
                for (int n = 0; n < PW; n++)
                    if (pw_data_q.size() < b_pw + PW || pw_data_q[b_pw+n] !== tr18[n]) m++;
                n_checks++; if (m !== 0) $display("FAIL klen_kw0_vs_kw18: %0d differ want 0", m); else n_pass++;
            end
        end
    endtask

    task automatic test_stub_chain();
        bit to;
        rand_mem();
        stub_lat = 3;
        run_seq(5'($urandom_range(1, 18)), 1'b0, '0, 1'b0, to);
        n_checks++; if (to) $display("FAIL chain_timeout"); else n_pass++;
        n_checks++; if (p_mem[0] !== 32'd1) $display("FAIL chain_P0: got %h want 1", p_mem[0]); else n_pass++;
        n_checks++; if (p_mem[1] !== 32'd2) $display("FAIL chain_P1: got %h want 2", p_mem[1]); else n_pass++;
        n_checks++; if (p_mem[2] !== 32'd2) $display("FAIL chain_P2: got %h want 2", p_mem[2]); else n_pass++;
        n_checks++; if (p_mem[3] !== 32'd4) $display("FAIL chain_P3: got %h want 4", p_mem[3]); else n_pass++;
        n_checks++; if (s_mem[1022] !== 32'd521) $display("FAIL chain_S1022: got %0d want 521", s_mem[1022]); else n_pass++;
        n_checks++; if (s_mem[1023] !== 32'd1042) $display("FAIL chain_S1023: got %0d want 1042", s_mem[1023]); else n_pass++;
        n_checks++; if (n_enc - b_enc !== NC) $display("FAIL chain_enc_starts: got %0d want %0d", n_enc - b_enc, NC); else n_pass++;
        n_checks++; if (n_done - b_done !== 1) $display("FAIL chain_done: got %0d want 1", n_done - b_done); else n_pass++;
        n_checks++; if (n_pw - b_pw !== 2*PW) $display("FAIL chain_p_writes: got %0d want %0d", n_pw - b_pw, 2*PW); else n_pass++;
        n_checks++; if (n_sw - b_sw !== SW) $display("FAIL chain_s_writes: got %0d want %0d", n_sw - b_sw, SW); else n_pass++;
        n_checks++; if (last_s !== 1023) $display("FAIL chain_last_s: got %0d want 1023", last_s); else n_pass++;
        n_checks++; if (n_multi - b_multi !== 0) $display("FAIL chain_dual_strobe: got %0d want 0", n_multi - b_multi); else n_pass++;
        n_checks++; if (mem_mm() !== 0) $display("FAIL chain_mem: %0d bad want 0", mem_mm()); else n_pass++;
    endtask

    task automatic test_salt();
        bit to;
        logic [127:0] sl;
        rand_mem();
        stub_lat = 3;
        run_seq(5'd4, 1'b1, 128'h00000001_00000002_00000003_00000004, 1'b0, to);
        n_checks++; if (to) $display("FAIL salt_timeout"); else n_pass++;
        n_checks++; if (xl_q[b_enc] !== 32'd1 || xr_q[b_enc] !== 32'd2)
            $display("FAIL salt_call0: got %h/%h want 1/2", xl_q[b_enc], xr_q[b_enc]); else n_pass++;
        n_checks++; if (xl_q[b_enc+1] !== 32'd1 || xr_q[b_enc+1] !== 32'd0)
            $display("FAIL salt_call1: got %h/%h want 1/0", xl_q[b_enc+1], xr_q[b_enc+1]); else n_pass++;
        n_checks++; if (enc_mm() !== 0) $display("FAIL salt_enc_trace: %0d bad want 0", enc_mm()); else n_pass++;
        n_checks++; if (mem_mm() !== 0) $display("FAIL salt_mem: %0d bad want 0", mem_mm()); else n_pass++;
        sl = {$urandom, $urandom, $urandom, $urandom};
        stub_lat = $urandom_range(1, 4);
        run_seq(5'($urandom_range(0, 31)), 1'b1, sl, 1'b0, to);
        n_checks++; if (to) $display("FAIL salt2_timeout"); else n_pass++;
        n_checks++; if (enc_mm() !== 0) $display("FAIL salt2_enc_trace: %0d bad want 0", enc_mm()); else n_pass++;
        n_checks++; if (mem_mm() !== 0) $display("FAIL salt2_mem: %0d bad want 0", mem_mm()); else n_pass++;
    endtask

    task automatic test_reset_mid();
        bit to;
        int wr_snap, enc_snap;
        rand_mem();
        stub_lat = 3;
        load_and_snap();
        key_words = 5'd5; use_salt = 1'b0; start = 1'b1;
        @(negedge clk); start = 1'b0;
        to = 1'b1;
        for (int c = 0; c < 5000; c++) begin
            if (n_enc - b_enc >= 101) begin to = 1'b0; break; end
            @(negedge clk); #1;
        end
        n_checks++; if (to) $display("FAIL rmid_reach_call100: got %0d calls", n_enc - b_enc); else n_pass++;
        @(negedge clk);
        n_checks++; if (p_own !== 1'b0) $display("FAIL rmid_wait_own: got %b want 0", p_own); else n_pass++;
        reset_l = 1'b0;
        #1;
        n_checks++; if (outs !== '0) $display("FAIL rmid_outs: got %h want 0", outs); else n_pass++;
        wr_snap = n_pw + n_sw; enc_snap = n_enc;
        repeat (4) @(negedge clk);
        reset_l = 1'b1;
        repeat (10) @(negedge clk);
        #1;
        n_checks++; if (n_pw + n_sw - wr_snap !== 0 || n_enc - enc_snap !== 0)
            $display("FAIL rmid_quiet: got %0d writes %0d starts want 0", n_pw + n_sw - wr_snap, n_enc - enc_snap); else n_pass++;
        n_checks++; if (outs !== '0) $display("FAIL rmid_idle_outs: got %h want 0", outs); else n_pass++;
        run_seq(5'($urandom_range(1, 18)), 1'b1, {$urandom, $urandom, $urandom, $urandom}, 1'b0, to);
        n_checks++; if (to) $display("FAIL rmid_rerun_timeout"); else n_pass++;
        n_checks++; if (mem_mm() !== 0) $display("FAIL rmid_rerun_mem: %0d bad want 0", mem_mm()); else n_pass++;
        n_checks++; if (n_enc - b_enc !== NC) $display("FAIL rmid_rerun_starts: got %0d want %0d", n_enc - b_enc, NC); else n_pass++;
    endtask

    task automatic test_ignore();
        bit to;
        int wr_snap, enc_snap;
        logic bad_outs;
        wr_snap = n_pw + n_sw; enc_snap = n_enc; bad_outs = 1'b0;
        for (int r = 0; r < 3; r++) begin
            @(negedge clk); inj_done = 1'b1;
            @(negedge clk); inj_done = 1'b0;
            #1; if (outs !== '0) bad_outs = 1'b1;
        end
        repeat (3) @(negedge clk);
        n_checks++; if (bad_outs !== 1'b0 || n_pw + n_sw + n_enc - wr_snap - enc_snap !== 0)
            $display("FAIL ign_idle_done: outs_bad=%b activity=%0d want 0/0", bad_outs, n_pw + n_sw + n_enc - wr_snap - enc_snap); else n_pass++;
        rand_mem();
        stub_lat = $urandom_range(1, 4);
        run_seq(5'($urandom_range(1, 18)), 1'b1, {$urandom, $urandom, $urandom, $urandom}, 1'b1, to);
        n_checks++; if (to) $display("FAIL ign_timeout"); else n_pass++;
        n_checks++; if (mem_mm() !== 0) $display("FAIL ign_mem: %0d bad want 0", mem_mm()); else n_pass++;
        n_checks++; if (enc_mm() !== 0) $display("FAIL ign_enc_trace: %0d bad want 0", enc_mm()); else n_pass++;
        n_checks++; if (n_done - b_done !== 1) $display("FAIL ign_done: got %0d want 1", n_done - b_done); else n_pass++;
        n_checks++; if (n_own_bad - b_own !== 0) $display("FAIL ign_own_at_start: got %0d want 0", n_own_bad - b_own); else n_pass++;
        n_checks++; if (p1_mm() !== 0) $display("FAIL ign_p1: %0d bad want 0", p1_mm()); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_key_one();
        test_key_len();
        test_stub_chain();
        test_salt();
        test_reset_mid();
        test_ignore();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
